ret_addr_ctrl: RTL

- PC sequencer and call/return controller. Sits directly upstream of the 12-bit, 8-entry return-address stack and drives its push, pop and data_in.
- On a call: pushes the return address and redirects the PC. On a return: consumes the stack's top-of-stack output and pops.
- Tracks stack occupancy so that overflow and underflow never corrupt the stack.

---
 rtl/ret_addr_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ret_addr_ctrl.sv
// PC sequencer and call/return controller for a return-address stack.
// On a call it pushes pc+1 and jumps to the target. On a return it takes
// the stack's top entry and pops. An occupancy counter blocks pushes when
// the stack is full and pops when it is empty. Any illegal request puts
// the controller in FAULT, and it stays there until rst_n is asserted.
module ret_addr_ctrl #(
  parameter int              PC_W     = 12,
  parameter int              DEPTH    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       is_call,
  input  logic                       is_ret,
  input  logic                       is_jump,
  input  logic                       br_taken,
  input  logic [PC_W-1:0]            target,
  input  logic [PC_W-1:0]            stk_top,
  output logic [PC_W-1:0]            pc,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [PC_W-1:0]            stk_data,
  output logic [$clog2(DEPTH):0]     depth,
  output logic                       ovf,
  output logic                       unf,
  output logic                       fault
);

  localparam int             DW        = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0]  DEPTH_MAX = DW'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [PC_W-1:0] pc_inc;

  // Sequential successor. It is also the return address pushed on a call,
  // and it wraps from all-ones to zero.
  assign pc_inc = pc_q + PC_W'(1);

  // State register. Reset clears the occupancy together with the stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments, so all registers update from pre-edge values.
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Next-state and stack strobes. Priority is ret > call > jump/branch > sequential.
  always_comb begin
    // NOTE: every output gets a hold/idle default first, so no path infers a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    depth_d  = depth_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;

    case (state_q)
      RUN: begin
        if (!stall) begin
          if (is_call && is_ret) begin
            // Contradictory decode: stop without touching the stack.
            state_d = FAULT;
          end else if (is_ret) begin
            if (depth_q != '0) begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
              depth_d = depth_q - DW'(1);
            end else begin
              unf_d   = 1'b1;
              state_d = FAULT;
            end
          end else if (is_call) begin
            if (depth_q != DEPTH_MAX) begin
              stk_push = 1'b1;
              pc_d     = target;
              depth_d  = depth_q + DW'(1);
            end else begin
              // Suppress the push so the stack pointer cannot wrap.
              ovf_d   = 1'b1;
              state_d = FAULT;
            end
          end else if (is_jump || br_taken) begin
            pc_d = target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      FAULT: begin
        // Everything stays frozen. Only rst_n leaves this state.
      end
      default: state_d = FAULT;
    endcase
  end

  assign pc       = pc_q;
  assign stk_data = pc_inc;
  assign depth    = depth_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign fault    = (state_q == FAULT);

endmodule
